fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage: owns the program counter, issues one instruction-bus request at a time, and presents a `fetch_data_t` bundle to the F/D pipeline register. It sits directly upstream of that register. It honours the hazard unit's fetch stall and takes branch and jump redirects from execute. Redirects squash any in-flight or buffered fetch.

## Interface
Parameters:
- `RESET_PC`, default 64'h0000_0000_8000_0000: PC loaded on reset.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `stallF` in 1: downstream cannot accept this cycle; same signal that deasserts the F/D register `en`.
- `redirect_valid` in 1: redirect request from execute.
- `redirect_pc` in 64: redirect target.
- `ireq_valid` out 1: instruction request valid.
- `ireq_addr` out 64: request address (= pc).
- `ireq_ready` in 1: address accepted this cycle.
- `iresp_valid` in 1: response data valid.
- `iresp_data` in 32: instruction word.
- `dataF` out `fetch_data_t`: {valid, misalign, pc[63:0], raw_instr[31:0]}; feeds the F/D register.
- `fetch_busy` out 1: fetch not holding an instruction; the hazard unit uses it for bubble accounting.

## Operation
- At most one request is outstanding. The FSM has four states: REQ, WAIT, HOLD, KILL.
- **REQ**
  - If `pc[1:0]!=0`: no bus request is issued. Capture {misalign=1, raw_instr=0} and go to HOLD.
  - Otherwise drive `ireq_valid=1`, `ireq_addr=pc`.
  - If `ireq_ready`, go to WAIT.
  - The bus permits retargeting before acceptance. A redirect with `ireq_ready=0` sets pc to `redirect_pc` and stays in REQ.
  - A redirect in the same cycle as `ireq_ready=1` goes to KILL with pc updated, because the accepted request is stale.
- **WAIT**
  - On `iresp_valid`, capture `iresp_data` into the hold register with misalign=0 and go to HOLD.
  - On redirect, go to KILL with pc updated. Redirect wins even if `iresp_valid` is high in the same cycle; that response is discarded and the state goes straight to REQ.
- **KILL**
  - Wait for `iresp_valid`, discard the data, then go to REQ.
  - A further redirect only updates pc.
- **HOLD**
  - `dataF.valid=1` with the captured pc, instr and misalign.
  - If `stallF=0`, the bundle transfers: pc becomes pc+4 (wraps modulo 2^64) and the state goes to REQ.
  - If `stallF=1`, hold everything.
  - On redirect, drop the buffer, set pc to `redirect_pc` and go to REQ, regardless of `stallF`.
- Priority: reset > redirect > response/accept > stall.
- `iresp_valid` in REQ or HOLD is ignored.
- `dataF` is all-zero outside HOLD. Downstream therefore latches a bubble (valid=0) when not stalled.
- `fetch_busy = (state != HOLD)`.

## Timing
- Outputs are combinational from registered state, pc and hold buffer only. There is no input-to-output combinational path except that `ireq_addr` equals the registered pc.
- **Reset** (cycle after `reset` is high):
  - state=REQ, pc=`RESET_PC`, hold buffer=0.
  - `ireq_valid=1`, `ireq_addr=RESET_PC`, `dataF='0`, `fetch_busy=1`.
  - Reset in any state abandons the outstanding request; the bus is reset by the same signal.
- **Latency:** request accepted at cycle t, response at t+k (k≥1), `dataF.valid` at t+k+1, next request at t+k+2 if no stall. Peak throughput is one instruction per 3 cycles with a zero-wait bus; that is accepted for this revision.
- **Redirect at cycle t:** new pc visible on `ireq_addr` at t+1 (from REQ or HOLD). From WAIT or KILL, the new pc is visible after the stale response has drained.

## Structure
- `fetch_data_t` lives in `pipes`; append the misalign field there.
- Add a `pipes` enum `fetch_state_t {F_REQ, F_WAIT, F_HOLD, F_KILL}`.
- Add `PC_STEP=4` to `pipes`.
- No sub-module; single FSM plus pc/hold registers. Target 150–250 lines.

## Test plan
- **Reset and first fetch:** reset 2 cycles, `ireq_ready=1` at cycle 1, `iresp_valid` with 32'h0000_0013 at cycle 3 → `ireq_addr=8000_0000` from cycle 0; `dataF`={1,0,8000_0000,0000_0013} at cycle 4; next `ireq_addr=8000_0004` at cycle 5.
- **Stall in HOLD:** `stallF=1` for 3 cycles → `dataF` unchanged, no new `ireq_valid`. pc advances only in the cycle `stallF` drops.
- **Redirect in WAIT:** redirect to 8000_0100 one cycle before the response arrives → response dropped, `dataF.valid` stays 0, then `ireq_addr=8000_0100`.
- **Redirect coinciding with `ireq_ready`:** state goes to KILL; the next request is `redirect_pc` only after one `iresp_valid` has been consumed.
- **Misaligned PC:** redirect to 8000_0102 → no `ireq_valid`; `dataF`={1,1,8000_0102,0} next cycle.
- **Reset mid-WAIT:** reset while WAIT is pending → REQ at `RESET_PC`, `dataF='0`, late `iresp_valid` ignored.

Source files
------------

// File: rtl/pipes.sv
// rtl/pipes.sv - pipeline-wide types and constants shared between stages
package pipes;

    localparam logic [63:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic        valid;
        logic        misalign;
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } fetch_data_t;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,
        F_WAIT = 2'd1,
        F_HOLD = 2'd2,
        F_KILL = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: pc owner, single-outstanding bus request, F/D bundle
module fetch_stage
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output fetch_data_t dataF,
    output logic        fetch_busy
);

    fetch_state_t state, state_n;
    logic [63:0]  pc, pc_n;
    logic [31:0]  hold_instr, hold_instr_n;
    logic         hold_misalign, hold_misalign_n;
    logic         pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= F_REQ;
            pc            <= RESET_PC;
            hold_instr    <= '0;
            hold_misalign <= 1'b0;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            hold_instr    <= hold_instr_n;
            hold_misalign <= hold_misalign_n;
        end
    end

    always_comb begin
        state_n         = state;
        pc_n            = pc;
        hold_instr_n    = hold_instr;
        hold_misalign_n = hold_misalign;

        case (state)
            F_REQ: begin
                if (!pc_aligned) begin
                    if (redirect_valid) begin
                        pc_n = redirect_pc;
                    end else begin
                        hold_instr_n    = '0;
                        hold_misalign_n = 1'b1;
                        state_n         = F_HOLD;
                    end
                end else if (redirect_valid) begin
                    // an accepted request in this cycle now targets a stale pc
                    pc_n = redirect_pc;
                    if (ireq_ready) state_n = F_KILL;
                end else if (ireq_ready) begin
                    state_n = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect_valid) begin
                    pc_n    = redirect_pc;
                    state_n = iresp_valid ? F_REQ : F_KILL;
                end else if (iresp_valid) begin
                    hold_instr_n    = iresp_data;
                    hold_misalign_n = 1'b0;
                    state_n         = F_HOLD;
                end
            end
            F_KILL: begin
                if (redirect_valid) pc_n = redirect_pc;
                if (iresp_valid) state_n = F_REQ;
            end
            F_HOLD: begin
                if (redirect_valid) begin
                    pc_n            = redirect_pc;
                    hold_instr_n    = '0;
                    hold_misalign_n = 1'b0;
                    state_n         = F_REQ;
                end else if (!stallF) begin
                    pc_n            = pc + PC_STEP;
                    hold_instr_n    = '0;
                    hold_misalign_n = 1'b0;
                    state_n         = F_REQ;
                end
            end
            default: state_n = F_REQ;
        endcase
    end

    assign ireq_valid = (state == F_REQ) && pc_aligned;
    assign ireq_addr  = pc;
    assign fetch_busy = (state != F_HOLD);

    always_comb begin
        dataF = '0;
        if (state == F_HOLD) begin
            dataF.valid     = 1'b1;
            dataF.misalign  = hold_misalign;
            dataF.pc        = pc;
            dataF.raw_instr = hold_instr;
        end
    end

endmodule
